// File: rtl/alu_ctrl_mdu_pkg.sv
// Shared constants for the EX-stage ALU control / RV32M iterative multiply-divide unit.
// Operation codes, M-extension Funct3 codes and the MDU sequencer states.
package alu_ctrl_pkg;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_XOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_BEQ = 4'b0101;
  localparam logic [3:0] OP_BNE = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_BGE = 4'b1000;
  localparam logic [3:0] OP_SRL = 4'b1001;
  localparam logic [3:0] OP_SLL = 4'b1010;
  localparam logic [3:0] OP_SRA = 4'b1011;
  localparam logic [3:0] OP_LUI = 4'b1100;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] FUNCT7_MEXT = 7'b0000001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_ADJ  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_t;

endpackage

// File: rtl/alu_ctrl_mdu_if.sv
// EX-stage bundle between the decode/forwarding logic and alu_ctrl_mdu.
// Combinational decode signals plus the md_stall/md_done handshake to the hazard unit.
interface alu_ctrl_mdu_if #(
  parameter int XLEN = 32,
  parameter int OP_W = 4
);
  logic [1:0]      ALUOp;
  logic [6:0]      Funct7;
  logic [2:0]      Funct3;
  logic            is_rtype;
  logic            ex_valid;
  logic            flush;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic [OP_W-1:0] Operation;
  logic            md_stall;
  logic            md_done;
  logic [XLEN-1:0] md_result;

  modport master (
    output ALUOp, Funct7, Funct3, is_rtype, ex_valid, flush, SrcA, SrcB,
    input  Operation, md_stall, md_done, md_result
  );

  modport slave (
    input  ALUOp, Funct7, Funct3, is_rtype, ex_valid, flush, SrcA, SrcB,
    output Operation, md_stall, md_done, md_result
  );
endinterface

// File: rtl/alu_ctrl_mdu_iter_core.sv
// Unsigned one-bit-per-cycle datapath: shift-add multiply or restoring divide on a 2*XLEN accumulator.
// XLEN step cycles after load; no backpressure, steps only while 'step' is high.
module mdu_iter_core #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a_in,
  input  logic [XLEN-1:0]   b_in,
  output logic [2*XLEN-1:0] acc,
  output logic              last
);
  localparam int CNT_W = $clog2(XLEN);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              div_q, div_d;
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     rem_sub;

  always_comb begin
    add_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : {XLEN{1'b0}})};
    // Partial remainder shifted left by one with the next dividend bit brought in.
    rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_sub = rem_sh - {1'b0, b_q};
    acc_d   = acc_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    if (load) begin
      acc_d = {{XLEN{1'b0}}, a_in};
      b_d   = b_in;
      cnt_d = '0;
      div_d = is_div;
    end else if (step) begin
      cnt_d = cnt_q + 1'b1;
      if (!div_q)
        acc_d = {add_sum, acc_q[XLEN-1:1]};
      else if (rem_sh >= {1'b0, b_q})
        acc_d = {rem_sub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else
        acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      div_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

  assign acc  = acc_q;
  assign last = (cnt_q == CNT_W'(XLEN - 1));
endmodule

// File: rtl/alu_ctrl_mdu.sv
// EX-stage ALU control decode plus iterative RV32M unit; M results muxed downstream by md_done.
// Decode is combinational; M ops take XLEN+2 cycles (MDU_EARLY_OUT_EN: trivial cases take 1) with md_stall held.
module alu_ctrl_mdu
  import alu_ctrl_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = 4
) (
  input logic           clk,
  input logic           rst_n,
  alu_ctrl_mdu_if.slave bus
);
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t        state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_a_q, neg_a_d, neg_b_q, neg_b_d;
  logic              div0_q, div0_d, ovf_q, ovf_d;
  logic [XLEN-1:0]   a_q, a_d, res_q, res_d;
  logic [3:0]        op_code;
  logic              md_req, start, a_sgn, b_sgn, in_neg_a, in_neg_b;
  logic              core_load, core_step, core_last, stall;
  logic [2*XLEN-1:0] core_acc, prod;
  logic [XLEN-1:0]   quo, rem, adj_res;

  function automatic logic [XLEN-1:0] special_res(input logic [2:0] f3, input logic [XLEN-1:0] a,
                                                  input logic div0);
    if (f3[1]) return div0 ? a : '0;
    return div0 ? '1 : a;
  endfunction

  assign md_req = bus.ex_valid && (bus.ALUOp == 2'b10) && bus.is_rtype && (bus.Funct7 == FUNCT7_MEXT);
  assign start  = md_req && !bus.flush && rst_n;

  always_comb begin
    op_code = OP_AND;
    case (bus.ALUOp)
      2'b00: op_code = OP_ADD;
      2'b01: case (bus.Funct3)
        3'b000:  op_code = OP_BEQ;
        3'b001:  op_code = OP_BNE;
        3'b100:  op_code = OP_SLT;
        3'b101:  op_code = OP_BGE;
        default: op_code = OP_AND;
      endcase
      2'b10: case (bus.Funct3)
        3'b000:  op_code = OP_ADD;
        3'b001:  op_code = OP_SLL;
        3'b010:  op_code = OP_SLT;
        3'b100:  op_code = OP_XOR;
        3'b101:  op_code = bus.Funct7[5] ? OP_SRA : OP_SRL;
        3'b110:  op_code = OP_OR;
        default: op_code = OP_AND;
      endcase
      default: op_code = OP_LUI;
    endcase
    if (md_req) op_code = OP_ADD;
  end

  assign bus.Operation = OP_W'(op_code);

  always_comb begin
    a_sgn = 1'b0;
    b_sgn = 1'b0;
    case (bus.Funct3)
      F3_MUL, F3_MULH, F3_DIV, F3_REM: begin a_sgn = 1'b1; b_sgn = 1'b1; end
      F3_MULHSU:                       a_sgn = 1'b1;
      default:                         ;
    endcase
    in_neg_a = a_sgn && bus.SrcA[XLEN-1];
    in_neg_b = b_sgn && bus.SrcB[XLEN-1];
  end

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (core_load),
    .step   (core_step),
    .is_div (bus.Funct3[2]),
    .a_in   (in_neg_a ? -bus.SrcA : bus.SrcA),
    .b_in   (in_neg_b ? -bus.SrcB : bus.SrcB),
    .acc    (core_acc),
    .last   (core_last)
  );

  always_comb begin
    prod = (neg_a_q ^ neg_b_q) ? -core_acc : core_acc;
    quo  = (neg_a_q ^ neg_b_q) ? -core_acc[XLEN-1:0] : core_acc[XLEN-1:0];
    rem  = neg_a_q ? -core_acc[2*XLEN-1:XLEN] : core_acc[2*XLEN-1:XLEN];
    if (!f3_q[2])
      adj_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (div0_q || ovf_q)
      adj_res = special_res(f3_q, a_q, div0_q);
    else
      adj_res = f3_q[1] ? rem : quo;
  end

  always_comb begin
    state_d   = state_q;
    f3_d      = f3_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    a_d       = a_q;
    res_d     = res_q;
    core_load = 1'b0;
    core_step = 1'b0;
    stall     = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        stall   = 1'b1;
        f3_d    = bus.Funct3;
        neg_a_d = in_neg_a;
        neg_b_d = in_neg_b;
        a_d     = bus.SrcA;
        div0_d  = (bus.SrcB == '0);
        ovf_d   = bus.Funct3[2] && !bus.Funct3[0] && (bus.SrcA == INT_MIN) && (bus.SrcB == '1);
`ifdef MDU_EARLY_OUT_EN
        if (bus.Funct3[2] ? (div0_d || ovf_d) : ((bus.SrcA == '0) || (bus.SrcB == '0))) begin
          state_d = S_DONE;
          res_d   = bus.Funct3[2] ? special_res(bus.Funct3, bus.SrcA, div0_d) : '0;
        end else begin
          core_load = 1'b1;
          state_d   = S_CALC;
        end
`else
        core_load = 1'b1;
        state_d   = S_CALC;
`endif
      end
      S_CALC: if (bus.flush) state_d = S_IDLE;
      else begin
        stall     = 1'b1;
        core_step = 1'b1;
        if (core_last) state_d = S_ADJ;
      end
      S_ADJ: if (bus.flush) state_d = S_IDLE;
      else begin
        stall   = 1'b1;
        res_d   = adj_res;
        state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      f3_q    <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
      a_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      f3_q    <= f3_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      div0_q  <= div0_d;
      ovf_q   <= ovf_d;
      a_q     <= a_d;
      res_q   <= res_d;
    end
  end

  assign bus.md_stall  = stall;
  assign bus.md_done   = (state_q == S_DONE) && !bus.flush;
  assign bus.md_result = res_q;
endmodule
